// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive frame controller: state
// encoding, the legal oversampling ratios and the edge-counter wrap rule.
package uart_rx_ctrl_pkg;

    localparam int PS_W = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic [PS_W-1:0] PRESCALE_8  = 6'd8;
    localparam logic [PS_W-1:0] PRESCALE_16 = 6'd16;
    localparam logic [PS_W-1:0] PRESCALE_32 = 6'd32;

    // Last edge_cnt value before wrapping; unsupported ratios behave as 8.
    function automatic logic [PS_W-1:0] wrap_value(input logic [PS_W-1:0] prescale);
        case (prescale)
            PRESCALE_16: return 6'd15;
            PRESCALE_32: return 6'd31;
            default:     return 6'd7;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling tick counter: counts ticks within the current bit while a
// frame is active and wraps at the prescale-dependent limit.
module uart_rx_edge_bit_cnt
    import uart_rx_ctrl_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk_RX,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] prescale,
    output logic [CNT_W-1:0] edge_cnt
);

    logic [CNT_W-1:0] wrap;

    assign wrap = CNT_W'(wrap_value(PS_W'(prescale)));

    // Hold at zero when idle or when the frame ends; otherwise count and wrap.
    // The >= compare recovers cleanly if prescale changes mid-frame.
    always_ff @(posedge clk_RX or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
        end else if (!en || clr) begin
            edge_cnt <= '0;
        end else if (edge_cnt >= wrap) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, LSB-first deserializing,
// optional parity check, stop check and registered result pulses.
// Sampler handshake: take_sample is held high while the sampler's vote is
// being formed; sampled_bit is taken only on its falling edge (the consume
// event), i.e. take_sample_d = 1 and take_sample = 0.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 6
) (
    input  logic              clk_RX,
    input  logic              rst,
    input  logic              RX_IN,
    input  logic [CNT_W-1:0]  prescale,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              sampled_bit,
    input  logic              take_sample,
    output logic [CNT_W-1:0]  edge_cnt,
    output logic              dat_samp_en,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DATA_W);

    rx_state_t         state;
    logic              take_sample_d;
    logic              consume;
    logic              cnt_clr;
    logic              par_en_l;
    logic              par_typ_l;
    logic              err;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;

    assign consume = take_sample_d && !take_sample;
    assign busy    = (state != IDLE);
    // The counter restarts at zero for the next frame once this one closes.
    assign cnt_clr = consume && ((state == STOP) || ((state == START) && sampled_bit));

    uart_rx_edge_bit_cnt #(
        .CNT_W (CNT_W)
    ) u_edge_cnt (
        .clk_RX   (clk_RX),
        .rst      (rst),
        .en       (busy),
        .clr      (cnt_clr),
        .prescale (prescale),
        .edge_cnt (edge_cnt)
    );

    // Delayed strobe used to find the falling edge of take_sample.
    always_ff @(posedge clk_RX or negedge rst) begin
        if (!rst) begin
            take_sample_d <= 1'b0;
        end else begin
            take_sample_d <= take_sample;
        end
    end

    // Frame FSM with deserializer, parity/stop checks and registered pulses.
    always_ff @(posedge clk_RX or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            dat_samp_en <= 1'b0;
            par_en_l    <= 1'b0;
            par_typ_l   <= 1'b0;
            err         <= 1'b0;
            shreg       <= '0;
            bit_idx     <= '0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        state       <= START;
                        par_en_l    <= PAR_EN;
                        par_typ_l   <= PAR_TYP;
                        dat_samp_en <= 1'b1;
                        err         <= 1'b0;
                        bit_idx     <= '0;
                    end
                end
                START: begin
                    if (consume) begin
                        if (sampled_bit) begin
                            state       <= IDLE;
                            dat_samp_en <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (consume) begin
                        shreg   <= {sampled_bit, shreg[DATA_W-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_W'(DATA_W - 1)) begin
                            state <= par_en_l ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (consume) begin
                        err   <= (sampled_bit != ((^shreg) ^ par_typ_l));
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (consume) begin
                        if (!sampled_bit) begin
                            stp_err <= 1'b1;
                        end else if (err) begin
                            par_err <= 1'b1;
                        end else begin
                            P_DATA     <= shreg;
                            data_valid <= 1'b1;
                        end
                        state       <= IDLE;
                        dat_samp_en <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    dat_samp_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: serial frames on RX_IN, a simple
// mid-bit sampler model driving take_sample/sampled_bit, pulse counters
// and an expected-byte queue.
module tb_uart_rx_ctrl;

    logic       clk_RX = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic [5:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       take_sample;
    logic [5:0] edge_cnt;
    logic       dat_samp_en;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    int         n_vec = 0;
    int         n_bad = 0;
    int         cnt_valid = 0;
    int         cnt_par = 0;
    int         cnt_stp = 0;
    int         max_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx_ctrl dut (
        .clk_RX      (clk_RX),
        .rst         (rst),
        .RX_IN       (RX_IN),
        .prescale    (prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .sampled_bit (sampled_bit),
        .take_sample (take_sample),
        .edge_cnt    (edge_cnt),
        .dat_samp_en (dat_samp_en),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy)
    );

    // clock
    always #5 clk_RX = ~clk_RX;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // sampler model: capture RX_IN mid-bit, strobe for two ticks after it
    always @(negedge clk_RX) begin
        int half;
        half = int'(prescale) / 2;
        if (dat_samp_en && int'(edge_cnt) == half) sampled_bit = RX_IN;
        take_sample = dat_samp_en && (int'(edge_cnt) == half + 1 || int'(edge_cnt) == half + 2);
    end

    // monitor and scoreboard
    always @(negedge clk_RX) begin
        if (data_valid) begin
            cnt_valid++;
            if (exp_q.size() == 0) chk("spare_valid", 32'(exp_q.size()), 32'd1);
            else                   chk("p_data", {24'd0, P_DATA}, {24'd0, exp_q.pop_front()});
        end
        if (par_err) cnt_par++;
        if (stp_err) cnt_stp++;
        if (int'(edge_cnt) > max_cnt) max_cnt = int'(edge_cnt);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_RX);
    endtask

    task automatic clear_counts();
        cnt_valid = 0;
        cnt_par   = 0;
        cnt_stp   = 0;
        max_cnt   = 0;
    endtask

    task automatic drive_bit(input logic b);
        RX_IN = b;
        idle(int'(prescale));
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb, input logic sb);
        drive_bit(1'b0);
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pe) drive_bit(pb);
        drive_bit(sb);
        RX_IN = 1'b1;
    endtask

    task automatic results(input string tag, input int v, input int p, input int s);
        chk({tag, "_valid"}, 32'(cnt_valid), 32'(v));
        chk({tag, "_par"}, 32'(cnt_par), 32'(p));
        chk({tag, "_stp"}, 32'(cnt_stp), 32'(s));
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_samp_en"}, {31'd0, dat_samp_en}, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        RX_IN       = 1'b1;
        prescale    = 6'd8;
        PAR_EN      = 1'b0;
        PAR_TYP     = 1'b0;
        take_sample = 1'b0;
        sampled_bit = 1'b0;
        #2 rst = 1'b0;
        idle(3);
        chk("rst_edge_cnt", {26'd0, edge_cnt}, 32'd0);
        chk("rst_samp_en", {31'd0, dat_samp_en}, 32'd0);
        chk("rst_p_data", {24'd0, P_DATA}, 32'd0);
        chk("rst_pulses", {29'd0, data_valid, par_err, stp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        idle(4);

        // 1: prescale 8, no parity, 0xA5
        clear_counts();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(16);
        results("t1", 1, 0, 0);
        chk("t1_max_cnt", 32'(max_cnt), 32'd7);

        // 2: prescale 16, even parity, 0x3C good then bad parity
        clear_counts();
        prescale = 6'd16;
        PAR_EN   = 1'b1;
        PAR_TYP  = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        idle(32);
        results("t2a", 1, 0, 0);
        chk("t2a_max_cnt", 32'(max_cnt), 32'd15);
        clear_counts();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        idle(32);
        results("t2b", 0, 1, 0);
        chk("t2b_p_data_held", {24'd0, P_DATA}, 32'h3C);

        // 3: prescale 32, odd parity, 0x00, stop bit 0 (parity good, then bad)
        clear_counts();
        prescale = 6'd32;
        PAR_TYP  = 1'b1;
        send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        idle(64);
        results("t3a", 0, 0, 1);
        chk("t3a_max_cnt", 32'(max_cnt), 32'd31);
        clear_counts();
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        idle(64);
        results("t3b", 0, 0, 1);
        chk("t3_p_data_held", {24'd0, P_DATA}, 32'h3C);

        // 4: 2-tick glitch on RX_IN
        clear_counts();
        prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        RX_IN    = 1'b0;
        idle(2);
        chk("t4_busy_start", {31'd0, busy}, 32'd1);
        RX_IN = 1'b1;
        idle(16);
        results("t4", 0, 0, 0);

        // 5: back-to-back 0x55, 0xFF at prescale 8
        clear_counts();
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hFF);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        idle(16);
        results("t5", 2, 0, 0);
        chk("t5_p_data_last", {24'd0, P_DATA}, 32'hFF);

        // 6: reset during data bit 4, then clean 0x81
        clear_counts();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        RX_IN = 1'b0;
        idle(4);
        chk("t6_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_edge_cnt", {26'd0, edge_cnt}, 32'd0);
        chk("t6_samp_en", {31'd0, dat_samp_en}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_p_data", {24'd0, P_DATA}, 32'd0);
        chk("t6_pulses", {29'd0, data_valid, par_err, stp_err}, 32'd0);
        RX_IN = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(8);
        results("t6_abort", 0, 0, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        idle(16);
        results("t6", 1, 0, 0);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Frame controller for the UART receiver. Detects the start edge on RX_IN, runs the oversampling edge counter, enables the data sampling stage, and consumes its majority-voted bit on each sample strobe. It deserializes 8 data bits LSB-first, checks optional parity and the stop bit, and delivers a parallel byte with a valid pulse. It is both upstream of the sampler (edge_cnt, dat_samp_en) and downstream of it (sampled_bit, take_sample).

Parameters:
DATA_W, 8, data bits per frame
CNT_W, 6, width of edge_cnt and prescale

Ports:
clk_RX  in  1  oversampling clock
rst  in  1  asynchronous active-low reset
RX_IN  in  1  serial line, idle high
prescale  in  6  oversampling ratio: 8, 16 or 32
PAR_EN  in  1  1 = parity bit present
PAR_TYP  in  1  0 = even, 1 = odd
sampled_bit  in  1  voted bit from the sampler
take_sample  in  1  sampler strobe, high for 2 cycles per bit
edge_cnt  out  6  oversampling tick index within the current bit
dat_samp_en  out  1  sampler enable
P_DATA  out  8  received byte
data_valid  out  1  1-cycle pulse: good frame on P_DATA
par_err  out  1  1-cycle pulse: parity mismatch
stp_err  out  1  1-cycle pulse: stop bit read as 0
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst low, async): state = IDLE; edge_cnt, P_DATA, the shift register, bit index and all pulses = 0; dat_samp_en = 0; busy = 0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: when RX_IN = 0 is sampled, go to START next cycle. On that cycle latch PAR_EN and PAR_TYP, clear edge_cnt, and raise dat_samp_en. Changes to PAR_EN or PAR_TYP mid-frame are ignored.
- Edge counter: increments every cycle while state != IDLE. It wraps to 0 after prescale-1. Prescale values other than 8, 16 or 32 are treated as 8 (wrap at 7). It is held at 0 in IDLE.
- Consume event: take_sample was 1 on the previous cycle and is 0 on this cycle. Detect this with a registered take_sample_d. All bit decisions happen only on consume events, never on edge_cnt wrap. For prescale 8 the event falls on edge_cnt 0 of the following bit; this is correct behaviour.
- START on consume: if sampled_bit = 1, treat it as a glitch. Go to IDLE, drop dat_samp_en, emit no pulses. If sampled_bit = 0, go to DATA with bit index 0.
- DATA on consume: shift sampled_bit in LSB-first (shreg <= {sampled_bit, shreg[7:1]}) and increment the bit index. After the 8th bit, go to PARITY if PAR_EN is latched, otherwise go to STOP.
- PARITY on consume: compute expected = ^shreg XOR PAR_TYP. Set an internal err flag if sampled_bit != expected. Go to STOP.
- STOP on consume:
  - sampled_bit = 0: pulse stp_err.
  - Else if the parity err flag is set: pulse par_err.
  - Else: load P_DATA <= shreg and pulse data_valid.
  - In all cases go to IDLE next cycle and drop dat_samp_en. The pulses are registered and appear the cycle after the consume event.
- A frame with both a parity error and a stop error pulses stp_err only.
- P_DATA holds its value until the next good frame; errored frames do not update it.
- A falling RX_IN during STOP is not a new start. It is detected in IDLE, giving up to 1 tick of skew; this is tolerated.
- Reset asserted mid-frame aborts immediately to reset values with no pulses.

Decomposition:
- Shared package: state encoding localparams (IDLE, START, DATA, PARITY, STOP), legal prescale constants (8, 16, 32), and the function wrap_value(prescale) returning 7, 15 or 31.
- One natural sub-module: uart_rx_edge_bit_cnt, containing the edge counter with its prescale-dependent wrap and enable.
- FSM, deserializer and checks stay in uart_rx_ctrl.

Test Plan:
1. Prescale 8, PAR_EN 0, byte 0xA5, stop 1 -> P_DATA = 0xA5, a single data_valid pulse after the stop consume, busy returns to 0, no error pulses.
2. Prescale 16, PAR_EN 1, PAR_TYP 0, byte 0x3C, parity 0 -> data_valid with P_DATA = 0x3C. Repeat with parity bit 1 -> par_err pulse and P_DATA stays 0x3C.
3. Prescale 32, odd parity, byte 0x00, parity 1, stop bit 0 -> stp_err only, no data_valid, no par_err.
4. RX_IN low for 2 ticks then high, with sampler voting 1 at start -> FSM back to IDLE, dat_samp_en low, no pulses.
5. Two back-to-back frames (0x55 then 0xFF) at prescale 8 -> two data_valid pulses with P_DATA = 0x55 then 0xFF.
6. Assert rst mid-DATA at bit 4 -> all outputs 0 immediately. A subsequent clean frame 0x81 is received correctly.
